// File: rtl/datapath_control_unit.sv
// Purpose: multi-cycle Moore sequencer driving every strobe of the 32-bit bus datapath (fetch T0-T2, execute T3-T7).
// Latency: outputs are decoded from the current state (and IR in T3..T7); one state step per clock.
// Backpressure: memory reads hold in T1 / ld-T6 until mem_ready; stop halts at the next instruction boundary.
module datapath_control_unit #(
  parameter int FETCH_WAIT_MAX = 0  // 0: wait for mem_ready forever; N>0: halt after N consecutive not-ready cycles
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  input  logic        stop,
  output logic        mem_read,
  output logic        md_mux_read,
  output logic        pc_out,
  output logic        pc_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        ir_in,
  output logic        y_in,
  output logic        z_in,
  output logic        zhigh_out,
  output logic        zlow_out,
  output logic        hi_in,
  output logic        lo_in,
  output logic        hi_out,
  output logic        lo_out,
  output logic        cse_out,
  output logic        inport_out,
  output logic [15:0] gp_in,
  output logic [15:0] gp_out,
  output logic [13:0] alu_op,
  output logic        run
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  // Instruction classes: opcodes sharing the same step sequence
  typedef enum logic [3:0] {
    C_NOP, C_ALU3, C_IMM, C_MULDIV, C_UNARY, C_LD, C_IN, C_MFHI, C_MFLO, C_HALT
  } cls_t;

  localparam int A_ADD   = 0;
  localparam int A_SUB   = 1;
  localparam int A_MUL   = 2;
  localparam int A_DIV   = 3;
  localparam int A_AND   = 4;
  localparam int A_OR    = 5;
  localparam int A_SHR   = 6;
  localparam int A_SHRA  = 7;
  localparam int A_SHL   = 8;
  localparam int A_ROR   = 9;
  localparam int A_ROL   = 10;
  localparam int A_NEG   = 11;
  localparam int A_NOT   = 12;
  localparam int A_INCPC = 13;

  state_t      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;

  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  cls_t        cls;
  logic [13:0] op_alu;
  logic        step_done;
  logic        mem_timeout;
  logic        unused_ir_bits;

  assign opcode = ir[31:27];
  assign ra     = ir[26:23];
  assign rb     = ir[22:19];
  assign rc     = ir[18:15];

  // The immediate field feeds the datapath through C-sign-extend, not this unit
  assign unused_ir_bits = ^ir[14:0];

  // A memory wait gives up only when a nonzero limit is configured and reached
  assign mem_timeout = (FETCH_WAIT_MAX != 0) &&
                       (({16'd0, wait_cnt_q} + 32'd1) >= 32'($unsigned(FETCH_WAIT_MAX)));

  function automatic logic [15:0] reg_oh(input logic [3:0] idx);
    reg_oh = 16'd1 << idx;
  endfunction

  // Opcode decode into a step-sequence class and the one-hot ALU operation
  always_comb begin
    cls    = C_NOP;
    op_alu = '0;
    case (opcode)
      5'b00010: begin cls = C_ALU3;   op_alu[A_ADD]  = 1'b1; end
      5'b00011: begin cls = C_ALU3;   op_alu[A_SUB]  = 1'b1; end
      5'b00100: begin cls = C_ALU3;   op_alu[A_AND]  = 1'b1; end
      5'b00101: begin cls = C_ALU3;   op_alu[A_OR]   = 1'b1; end
      5'b00110: begin cls = C_ALU3;   op_alu[A_SHR]  = 1'b1; end
      5'b00111: begin cls = C_ALU3;   op_alu[A_SHRA] = 1'b1; end
      5'b01000: begin cls = C_ALU3;   op_alu[A_SHL]  = 1'b1; end
      5'b01001: begin cls = C_ALU3;   op_alu[A_ROR]  = 1'b1; end
      5'b01010: begin cls = C_ALU3;   op_alu[A_ROL]  = 1'b1; end
      5'b01011: begin cls = C_IMM;    op_alu[A_ADD]  = 1'b1; end
      5'b01100: begin cls = C_IMM;    op_alu[A_AND]  = 1'b1; end
      5'b01101: begin cls = C_IMM;    op_alu[A_OR]   = 1'b1; end
      5'b01110: begin cls = C_MULDIV; op_alu[A_MUL]  = 1'b1; end
      5'b01111: begin cls = C_MULDIV; op_alu[A_DIV]  = 1'b1; end
      5'b10000: begin cls = C_UNARY;  op_alu[A_NEG]  = 1'b1; end
      5'b10001: begin cls = C_UNARY;  op_alu[A_NOT]  = 1'b1; end
      5'b00000: begin cls = C_LD;     op_alu[A_ADD]  = 1'b1; end
      5'b10100: cls = C_IN;
      5'b10110: cls = C_MFHI;
      5'b10111: cls = C_MFLO;
      5'b11001: cls = C_HALT;
      default:  cls = C_NOP;
    endcase
  end

  // State and memory-wait counter registers; clear abandons everything at once
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state and Moore strobe decode
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = '0;
    step_done   = 1'b0;
    mem_read    = 1'b0;
    md_mux_read = 1'b0;
    pc_out      = 1'b0;
    pc_in       = 1'b0;
    mar_in      = 1'b0;
    mdr_in      = 1'b0;
    mdr_out     = 1'b0;
    ir_in       = 1'b0;
    y_in        = 1'b0;
    z_in        = 1'b0;
    zhigh_out   = 1'b0;
    zlow_out    = 1'b0;
    hi_in       = 1'b0;
    lo_in       = 1'b0;
    hi_out      = 1'b0;
    lo_out      = 1'b0;
    cse_out     = 1'b0;
    inport_out  = 1'b0;
    gp_in       = '0;
    gp_out      = '0;
    alu_op      = '0;
    run         = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_T0;

      S_T0: begin
        pc_out         = 1'b1;
        mar_in         = 1'b1;
        alu_op[A_INCPC] = 1'b1;
        z_in           = 1'b1;
        state_d        = S_T1;
      end

      // PC reloads the same Z value on every stall cycle, which is harmless
      S_T1: begin
        zlow_out    = 1'b1;
        pc_in       = 1'b1;
        mem_read    = 1'b1;
        md_mux_read = 1'b1;
        mdr_in      = 1'b1;
        if (mem_ready) begin
          state_d = S_T2;
        end else if (mem_timeout) begin
          state_d = S_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end

      S_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
        state_d = S_T3;
      end

      S_T3: begin
        case (cls)
          C_ALU3, C_IMM, C_LD: begin
            gp_out  = reg_oh(rb);
            y_in    = 1'b1;
            state_d = S_T4;
          end
          C_MULDIV: begin
            gp_out  = reg_oh(ra);
            y_in    = 1'b1;
            state_d = S_T4;
          end
          C_UNARY: begin
            gp_out  = reg_oh(rb);
            alu_op  = op_alu;
            z_in    = 1'b1;
            state_d = S_T4;
          end
          C_IN: begin
            inport_out = 1'b1;
            gp_in      = reg_oh(ra);
            step_done  = 1'b1;
          end
          C_MFHI: begin
            hi_out    = 1'b1;
            gp_in     = reg_oh(ra);
            step_done = 1'b1;
          end
          C_MFLO: begin
            lo_out    = 1'b1;
            gp_in     = reg_oh(ra);
            step_done = 1'b1;
          end
          C_HALT:  state_d = S_HALT;
          default: step_done = 1'b1;
        endcase
      end

      S_T4: begin
        case (cls)
          C_ALU3: begin
            gp_out  = reg_oh(rc);
            alu_op  = op_alu;
            z_in    = 1'b1;
            state_d = S_T5;
          end
          C_IMM, C_LD: begin
            cse_out = 1'b1;
            alu_op  = op_alu;
            z_in    = 1'b1;
            state_d = S_T5;
          end
          C_MULDIV: begin
            gp_out  = reg_oh(rb);
            alu_op  = op_alu;
            z_in    = 1'b1;
            state_d = S_T5;
          end
          C_UNARY: begin
            zlow_out  = 1'b1;
            gp_in     = reg_oh(ra);
            step_done = 1'b1;
          end
          default: step_done = 1'b1;
        endcase
      end

      S_T5: begin
        case (cls)
          C_ALU3, C_IMM: begin
            zlow_out  = 1'b1;
            gp_in     = reg_oh(ra);
            step_done = 1'b1;
          end
          C_MULDIV: begin
            zlow_out = 1'b1;
            lo_in    = 1'b1;
            state_d  = S_T6;
          end
          C_LD: begin
            zlow_out = 1'b1;
            mar_in   = 1'b1;
            state_d  = S_T6;
          end
          default: step_done = 1'b1;
        endcase
      end

      S_T6: begin
        case (cls)
          C_MULDIV: begin
            zhigh_out = 1'b1;
            hi_in     = 1'b1;
            step_done = 1'b1;
          end
          C_LD: begin
            mem_read    = 1'b1;
            md_mux_read = 1'b1;
            mdr_in      = 1'b1;
            if (mem_ready) begin
              state_d = S_T7;
            end else if (mem_timeout) begin
              state_d = S_HALT;
            end else begin
              wait_cnt_d = wait_cnt_q + 16'd1;
            end
          end
          default: step_done = 1'b1;
        endcase
      end

      S_T7: begin
        if (cls == C_LD) begin
          mdr_out = 1'b1;
          gp_in   = reg_oh(ra);
        end
        step_done = 1'b1;
      end

      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    // Instruction boundary: honour a pending stop request
    if (step_done) begin
      state_d = stop ? S_HALT : S_T0;
    end

    run = (state_q != S_IDLE) && (state_q != S_HALT);
  end

endmodule

// File: tb/tb_datapath_control_unit.sv
// Directed bench for datapath_control_unit: fetch, stalls, ALU/mul/ld/misc opcodes, halt, stop and clear.
// Outputs are sampled on the falling clock edge; inputs change there too.
// Every strobe, gp_in, gp_out and alu_op is compared as one vector per step.
module tb_datapath_control_unit;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] ir;
  logic        mem_ready;
  logic        stop;
  logic        mem_read, md_mux_read, pc_out, pc_in, mar_in, mdr_in, mdr_out, ir_in;
  logic        y_in, z_in, zhigh_out, zlow_out, hi_in, lo_in, hi_out, lo_out;
  logic        cse_out, inport_out, run;
  logic [15:0] gp_in, gp_out;
  logic [13:0] alu_op;

  int errors = 0;
  int checks = 0;

  // Strobe masks in the order of the observed strobe vector below
  localparam logic [18:0] MR   = 19'h1 << 18;
  localparam logic [18:0] MDM  = 19'h1 << 17;
  localparam logic [18:0] PCO  = 19'h1 << 16;
  localparam logic [18:0] PCI  = 19'h1 << 15;
  localparam logic [18:0] MARI = 19'h1 << 14;
  localparam logic [18:0] MDRI = 19'h1 << 13;
  localparam logic [18:0] MDRO = 19'h1 << 12;
  localparam logic [18:0] IRI  = 19'h1 << 11;
  localparam logic [18:0] YI   = 19'h1 << 10;
  localparam logic [18:0] ZI   = 19'h1 << 9;
  localparam logic [18:0] ZHO  = 19'h1 << 8;
  localparam logic [18:0] ZLO  = 19'h1 << 7;
  localparam logic [18:0] HII  = 19'h1 << 6;
  localparam logic [18:0] LOI  = 19'h1 << 5;
  localparam logic [18:0] HIO  = 19'h1 << 4;
  localparam logic [18:0] LOO  = 19'h1 << 3;
  localparam logic [18:0] CSE  = 19'h1 << 2;
  localparam logic [18:0] INP  = 19'h1 << 1;
  localparam logic [18:0] RUN  = 19'h1;

  always #5 clock = ~clock;

  datapath_control_unit dut (
    .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready), .stop(stop),
    .mem_read(mem_read), .md_mux_read(md_mux_read), .pc_out(pc_out), .pc_in(pc_in),
    .mar_in(mar_in), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in),
    .z_in(z_in), .zhigh_out(zhigh_out), .zlow_out(zlow_out), .hi_in(hi_in), .lo_in(lo_in),
    .hi_out(hi_out), .lo_out(lo_out), .cse_out(cse_out), .inport_out(inport_out),
    .gp_in(gp_in), .gp_out(gp_out), .alu_op(alu_op), .run(run)
  );

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [18:0] s, input logic [15:0] gi,
                     input logic [15:0] go, input logic [13:0] al);
    logic [64:0] obs;
    logic [64:0] exp_v;
    obs = {mem_read, md_mux_read, pc_out, pc_in, mar_in, mdr_in, mdr_out, ir_in, y_in, z_in,
           zhigh_out, zlow_out, hi_in, lo_in, hi_out, lo_out, cse_out, inport_out, run,
           gp_in, gp_out, alu_op};
    exp_v = {s, gi, go, al};
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Entered at a falling edge while in T0; leaves the unit in T3 with ir loaded
  task automatic fetch(input string tag, input logic [31:0] instr, input int stall);
    chk({tag, "_t0"}, RUN | PCO | MARI | ZI, 16'h0, 16'h0, 14'h2000);
    mem_ready = (stall == 0);
    tick();
    for (int i = 0; i <= stall; i++) begin
      mem_ready = (i == stall);
      chk({tag, "_t1"}, RUN | ZLO | PCI | MR | MDM | MDRI, 16'h0, 16'h0, 14'h0);
      tick();
    end
    chk({tag, "_t2"}, RUN | MDRO | IRI, 16'h0, 16'h0, 14'h0);
    ir = instr;
    tick();
  endtask

  initial begin
    clear     = 1'b1;
    ir        = 32'h0;
    mem_ready = 1'b1;
    stop      = 1'b0;
    @(negedge clock);
    chk("reset_idle", 19'h0, 16'h0, 16'h0, 14'h0);
    clear = 1'b0;
    tick();

    // add R3,R1,R2
    fetch("add", {5'b00010, 4'd3, 4'd1, 4'd2, 15'd0}, 0);
    chk("add_t3", RUN | YI, 16'h0, 16'h0002, 14'h0);
    tick();
    chk("add_t4", RUN | ZI, 16'h0, 16'h0004, 14'h0001);
    tick();
    chk("add_t5", RUN | ZLO, 16'h0008, 16'h0, 14'h0);
    tick();

    // sub R2,R3,R4 behind a 3-cycle fetch stall
    fetch("sub", {5'b00011, 4'd2, 4'd3, 4'd4, 15'd0}, 3);
    chk("sub_t3", RUN | YI, 16'h0, 16'h0008, 14'h0);
    tick();
    chk("sub_t4", RUN | ZI, 16'h0, 16'h0010, 14'h0002);
    tick();
    chk("sub_t5", RUN | ZLO, 16'h0004, 16'h0, 14'h0);
    tick();

    // mul R4,R5
    fetch("mul", 32'h7228_0000, 0);
    chk("mul_t3", RUN | YI, 16'h0, 16'h0010, 14'h0);
    tick();
    chk("mul_t4", RUN | ZI, 16'h0, 16'h0020, 14'h0004);
    tick();
    chk("mul_t5", RUN | ZLO | LOI, 16'h0, 16'h0, 14'h0);
    tick();
    chk("mul_t6", RUN | ZHO | HII, 16'h0, 16'h0, 14'h0);
    tick();

    // ld R1,0x10(R2) with the data read held off for 2 cycles
    fetch("ld", 32'h0090_0010, 0);
    chk("ld_t3", RUN | YI, 16'h0, 16'h0004, 14'h0);
    tick();
    chk("ld_t4", RUN | CSE | ZI, 16'h0, 16'h0, 14'h0001);
    tick();
    chk("ld_t5", RUN | ZLO | MARI, 16'h0, 16'h0, 14'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 2);
      chk("ld_t6", RUN | MR | MDM | MDRI, 16'h0, 16'h0, 14'h0);
      tick();
    end
    chk("ld_t7", RUN | MDRO, 16'h0002, 16'h0, 14'h0);
    tick();

    // neg R6,R9
    fetch("neg", {5'b10000, 4'd6, 4'd9, 4'd0, 15'd0}, 0);
    chk("neg_t3", RUN | ZI, 16'h0, 16'h0200, 14'h0800);
    tick();
    chk("neg_t4", RUN | ZLO, 16'h0040, 16'h0, 14'h0);
    tick();

    // andi R1,R2,imm
    fetch("andi", {5'b01100, 4'd1, 4'd2, 4'd0, 15'h0055}, 0);
    chk("andi_t3", RUN | YI, 16'h0, 16'h0004, 14'h0);
    tick();
    chk("andi_t4", RUN | CSE | ZI, 16'h0, 16'h0, 14'h0010);
    tick();
    chk("andi_t5", RUN | ZLO, 16'h0002, 16'h0, 14'h0);
    tick();

    // mfhi R15, in R0, nop, undefined opcode: single-step instructions
    fetch("mfhi", {5'b10110, 4'd15, 23'd0}, 0);
    chk("mfhi_t3", RUN | HIO, 16'h8000, 16'h0, 14'h0);
    tick();
    fetch("in", {5'b10100, 4'd0, 23'd0}, 0);
    chk("in_t3", RUN | INP, 16'h0001, 16'h0, 14'h0);
    tick();
    fetch("nop", 32'hC000_0000, 0);
    chk("nop_t3", RUN, 16'h0, 16'h0, 14'h0);
    tick();
    fetch("undef", 32'hF800_0000, 0);
    chk("undef_t3", RUN, 16'h0, 16'h0, 14'h0);
    tick();

    // clear in T4 of add: strobes drop at once, T0 follows release
    fetch("clr", {5'b00010, 4'd3, 4'd1, 4'd2, 15'd0}, 0);
    tick();
    clear = 1'b1;
    #1;
    chk("clr_immediate", 19'h0, 16'h0, 16'h0, 14'h0);
    tick();
    chk("clr_held", 19'h0, 16'h0, 16'h0, 14'h0);
    clear = 1'b0;
    #1;
    chk("clr_idle", 19'h0, 16'h0, 16'h0, 14'h0);
    tick();

    // stop during T5 of add: HALT instead of T0, and it sticks
    fetch("stp", {5'b00010, 4'd3, 4'd1, 4'd2, 15'd0}, 0);
    tick();
    tick();
    chk("stp_t5", RUN | ZLO, 16'h0008, 16'h0, 14'h0);
    stop = 1'b1;
    tick();
    chk("stp_halt", 19'h0, 16'h0, 16'h0, 14'h0);
    stop = 1'b0;
    tick();
    chk("stp_halt_kept", 19'h0, 16'h0, 16'h0, 14'h0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();

    // halt opcode
    fetch("hlt", 32'hC800_0000, 0);
    chk("hlt_t3", RUN, 16'h0, 16'h0, 14'h0);
    tick();
    chk("hlt_halt", 19'h0, 16'h0, 16'h0, 14'h0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    chk("hlt_after_stop", 19'h0, 16'h0, 16'h0, 14'h0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    chk("hlt_idle", 19'h0, 16'h0, 16'h0, 14'h0);
    tick();
    chk("hlt_restart_t0", RUN | PCO | MARI | ZI, 16'h0, 16'h0, 14'h2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
